// File: rtl/mmm_nlp_pkg.sv
// Shared constants for the NLP/Karatsuba Montgomery multiplier family:
// digit geometry and the state encoding of the REDC stage-2 sequencer.
package mmm_nlp_pkg;

  localparam int DIVW = 87;        // reduction digit width
  localparam int NDIG = 3;         // digits per REDC, R = 2^(NDIG*DIVW) = 2^261
  localparam int MW   = 256;       // modulus width
  localparam int IDW  = 522;       // incoming product width
  localparam int ACW  = IDW + 1;   // accumulator width (one carry bit of headroom)
  localparam int PW   = DIVW + MW; // shared multiplier product width (343)

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_QCALC = 3'd1;
  localparam logic [2:0] ST_ACCUM = 3'd2;
  localparam logic [2:0] ST_FSUB  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/mmm_redc_256b_3way_chk.sv
// Simulation checks for the REDC stage: digit cancellation and the input
// precondition T < M*2^261. Only observes; drives nothing.
module mmm_redc_256b_3way_chk
  import mmm_nlp_pkg::*;
(
  input logic            i_clk,
  input logic            i_rstn,
  input logic [2:0]      state_i,
  input logic [DIVW-1:0] sum_lo_i,
  input logic            accept_i,
  input logic [IDW-1:0]  t_i,
  input logic [MW-1:0]   m_i
);

  // Check that each ACCUM step cancels the low digit and that accepted inputs meet T < M*2^261.
  always @(posedge i_clk) begin
    if (i_rstn && state_i == ST_ACCUM) begin
      assert (sum_lo_i == {DIVW{1'b0}})
        else $error("redc: low digit of acc+q*m not zero");
    end
    if (i_rstn && accept_i) begin
      assert (t_i < {5'd0, m_i, 261'd0})
        else $error("redc: precondition T < M*2^261 violated");
    end
  end

endmodule

// File: rtl/mmm_redc_mul_87x256.sv
// Combinational 87x256 unsigned multiplier shared by the REDC datapath.
// Kept as its own module so it can be replaced by the NLP multiplier or a
// pipelined version without touching the sequencer.
module mmm_redc_mul_87x256
  import mmm_nlp_pkg::*;
(
  input  logic [DIVW-1:0] a_i,
  input  logic [MW-1:0]   b_i,
  output logic [PW-1:0]   p_o
);

  assign p_o = PW'(a_i) * PW'(b_i);

endmodule

// File: rtl/mmm_redc_256b_3way.sv
// Stage-2 Montgomery REDC for the 256-bit 3-way multiplier.
// Digit-serial reduction over three 87-bit digits with one shared 87x256
// multiplier: QCALC forms q = acc_lo*M' mod 2^87, ACCUM forms
// (acc + q*M) >> 87. A final conditional subtract gives T*2^-261 mod M.
module mmm_redc_256b_3way
  import mmm_nlp_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_vld,
  output logic            o_rdy,
  input  logic [IDW-1:0]  i_t,
  input  logic [MW-1:0]   i_m,
  input  logic [DIVW-1:0] i_mp,
  output logic            o_vld,
  input  logic            i_rdy,
  output logic [MW-1:0]   o_res
);

  logic [2:0]      state_q, state_d;
  logic [ACW-1:0]  acc_q,   acc_d;
  logic [MW-1:0]   m_q,     m_d;
  logic [DIVW-1:0] mp_q,    mp_d;
  logic [DIVW-1:0] qd_q,    qd_d;
  logic [1:0]      cnt_q,   cnt_d;
  logic [MW-1:0]   res_q,   res_d;
  logic            vld_q,   vld_d;

  logic [DIVW-1:0] mul_a;
  logic [MW-1:0]   mul_b;
  logic [PW-1:0]   mul_p;
  logic [ACW-1:0]  sum;
  logic            accept;

  assign o_rdy  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & i_rdy);
  assign accept = i_vld & o_rdy;
  assign o_vld  = vld_q;
  assign o_res  = res_q;
  assign sum    = acc_q + ACW'(mul_p);

  // Shared multiplier operand select: (q, M) while accumulating, (acc_lo, M') otherwise.
  always_comb begin
    mul_a = acc_q[DIVW-1:0];
    mul_b = {{(MW-DIVW){1'b0}}, mp_q};
    case (state_q)
      ST_ACCUM: begin
        mul_a = qd_q;
        mul_b = m_q;
      end
      default: begin
        mul_a = acc_q[DIVW-1:0];
        mul_b = {{(MW-DIVW){1'b0}}, mp_q};
      end
    endcase
  end

  mmm_redc_mul_87x256 u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  // Sequencer next-state: operand capture, digit iterations, final subtract, output handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    m_d     = m_q;
    mp_d    = mp_q;
    qd_d    = qd_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    vld_d   = vld_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          acc_d   = {1'b0, i_t};
          m_d     = i_m;
          mp_d    = i_mp;
          cnt_d   = 2'd0;
          state_d = ST_QCALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_QCALC: begin
        qd_d    = mul_p[DIVW-1:0];
        state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        acc_d = sum >> DIVW;
        if (cnt_q == 2'(NDIG - 1)) begin
          state_d = ST_FSUB;
        end else begin
          cnt_d   = cnt_q + 2'd1;
          state_d = ST_QCALC;
        end
      end
      ST_FSUB: begin
        // acc < 2M here, so one conditional subtract fully reduces it.
        if (acc_q[MW:0] >= {1'b0, m_q}) begin
          res_d = acc_q[MW-1:0] - m_q;
        end else begin
          res_d = acc_q[MW-1:0];
        end
        vld_d   = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (i_rdy) begin
          vld_d = 1'b0;
          if (i_vld) begin
            acc_d   = {1'b0, i_t};
            m_d     = i_m;
            mp_d    = i_mp;
            cnt_d   = 2'd0;
            state_d = ST_QCALC;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      acc_q   <= {ACW{1'b0}};
      m_q     <= {MW{1'b0}};
      mp_q    <= {DIVW{1'b0}};
      qd_q    <= {DIVW{1'b0}};
      cnt_q   <= 2'd0;
      res_q   <= {MW{1'b0}};
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      mp_q    <= mp_d;
      qd_q    <= qd_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
    end
  end

  mmm_redc_256b_3way_chk u_chk (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .state_i  (state_q),
    .sum_lo_i (sum[DIVW-1:0]),
    .accept_i (accept),
    .t_i      (i_t),
    .m_i      (i_m)
  );

endmodule

// File: tb/tb_mmm_redc_256b_3way.sv
// Directed bench for the 256-bit 3-way Montgomery REDC stage.
module tb_mmm_redc_256b_3way;
  import mmm_nlp_pkg::*;

  logic            i_clk  = 1'b0;
  logic            i_rstn = 1'b0;
  logic            i_vld  = 1'b0;
  logic            i_rdy  = 1'b0;
  logic [IDW-1:0]  i_t    = '0;
  logic [MW-1:0]   i_m    = '0;
  logic [DIVW-1:0] i_mp   = '0;
  logic            o_rdy;
  logic            o_vld;
  logic [MW-1:0]   o_res;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mmm_redc_256b_3way dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_vld  (i_vld),
    .o_rdy  (o_rdy),
    .i_t    (i_t),
    .i_m    (i_m),
    .i_mp   (i_mp),
    .o_vld  (o_vld),
    .i_rdy  (i_rdy),
    .o_res  (o_res)
  );

  always #5 i_clk = ~i_clk;

  // free-running cycle counter used to measure result spacing
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [ACW-1:0] obs, input logic [ACW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_vld(output int lat);
    lat = 0;
    while (o_vld !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  // -M^-1 mod 2^87 by Newton iteration (3 -> 96 correct bits)
  function automatic logic [DIVW-1:0] calc_mp(input logic [MW-1:0] m);
    logic [DIVW-1:0] x;
    logic [DIVW-1:0] ml;
    ml = m[DIVW-1:0];
    x  = ml;
    for (int i = 0; i < 5; i++) x = x * (87'd2 - ml * x);
    return 87'd0 - x;
  endfunction

  // bit-serial Montgomery reference: T * 2^-261 mod M
  function automatic logic [MW-1:0] redc_model(input logic [IDW-1:0] t, input logic [MW-1:0] m);
    logic [IDW+1:0] r;
    r = {2'b00, t};
    for (int i = 0; i < 261; i++) begin
      if (r[0]) r = r + {268'd0, m};
      r = r >> 1;
    end
    if (r >= {268'd0, m}) r = r - {268'd0, m};
    return r[MW-1:0];
  endfunction

  function automatic logic [MW-1:0] rand_below(input logic [MW-1:0] m);
    logic [MW-1:0] v;
    v = {$urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    v[MW-1] = 1'b0;
    if (v >= m) v = v - m;
    return v;
  endfunction

  task automatic run_txn(input string tag, input logic [IDW-1:0] t, input logic [MW-1:0] exp);
    int lat;
    i_t   = t;
    i_vld = 1'b1;
    chk({tag, "_rdy"}, ACW'(o_rdy), ACW'(1'b1));
    step();
    i_vld = 1'b0;
    chk({tag, "_busy"}, ACW'(o_rdy), ACW'(1'b0));
    wait_vld(lat);
    chk({tag, "_lat"}, ACW'(lat), ACW'(7));
    chk({tag, "_res"}, ACW'(o_res), ACW'(exp));
    i_rdy = 1'b1;
    step();
    i_rdy = 1'b0;
    chk({tag, "_vld_clr"}, ACW'(o_vld), ACW'(1'b0));
  endtask

  initial begin
    logic [MW-1:0]  m;
    logic [MW-1:0]  a, b, c, d;
    logic [IDW-1:0] t, t1, t2, e_tmp;
    logic [MW-1:0]  e, e1, e2;
    int lat, cyc1, cyc2;

    m    = 256'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;
    i_m  = m;
    i_mp = calc_mp(m);

    // reset state
    #12;
    chk("rst_vld", ACW'(o_vld), ACW'(1'b0));
    chk("rst_res", ACW'(o_res), ACW'(0));
    chk("rst_rdy", ACW'(o_rdy), ACW'(1'b1));
    i_rstn = 1'b1;
    step();

    // directed boundary vectors
    run_txn("t_zero", 522'd0, 256'd0);
    t = 522'd1 << 261;
    run_txn("t_r", t, 256'd1);
    t = {266'd0, m - 256'd1} << 261;
    run_txn("t_mm1r", t, m - 256'd1);
    e_tmp = {266'd0, m};
    t = (e_tmp << 261) - e_tmp;
    run_txn("t_mrm1", t, 256'd0);

    // random product with output stall and ignored input pulses
    a = rand_below(m);
    b = rand_below(m);
    t = {266'd0, a} * {266'd0, b};
    e = redc_model(t, m);
    i_t   = t;
    i_vld = 1'b1;
    step();
    i_vld = 1'b0;
    wait_vld(lat);
    chk("stall_lat", ACW'(lat), ACW'(7));
    chk("stall_res", ACW'(o_res), ACW'(e));
    for (int k = 0; k < 5; k++) begin
      i_vld = (k % 2 == 0);
      i_t   = 522'd1 << 261;
      step();
      chk("stall_vld", ACW'(o_vld), ACW'(1'b1));
      chk("stall_hold", ACW'(o_res), ACW'(e));
      chk("stall_rdy", ACW'(o_rdy), ACW'(1'b0));
    end
    i_vld = 1'b0;
    i_rdy = 1'b1;
    step();
    i_rdy = 1'b0;
    chk("stall_rel_vld", ACW'(o_vld), ACW'(1'b0));
    chk("stall_rel_idle", ACW'(o_rdy), ACW'(1'b1));

    // back-to-back products
    a  = rand_below(m);
    b  = rand_below(m);
    c  = rand_below(m);
    d  = rand_below(m);
    t1 = {266'd0, a} * {266'd0, b};
    t2 = {266'd0, c} * {266'd0, d};
    e1 = redc_model(t1, m);
    e2 = redc_model(t2, m);
    i_rdy = 1'b1;
    i_vld = 1'b1;
    i_t   = t1;
    step();
    i_t = t2;
    wait_vld(lat);
    cyc1 = cyc;
    chk("b2b_lat1", ACW'(lat), ACW'(7));
    chk("b2b_res1", ACW'(o_res), ACW'(e1));
    chk("b2b_rdy_done", ACW'(o_rdy), ACW'(1'b1));
    step();
    i_vld = 1'b0;
    wait_vld(lat);
    cyc2 = cyc;
    chk("b2b_gap", ACW'(cyc2 - cyc1), ACW'(8));
    chk("b2b_res2", ACW'(o_res), ACW'(e2));
    step();
    i_rdy = 1'b0;
    chk("b2b_idle", ACW'(o_rdy), ACW'(1'b1));

    // reset during the second ACCUM
    i_t   = t1;
    i_vld = 1'b1;
    step();
    i_vld = 1'b0;
    step();
    step();
    step();
    i_rstn = 1'b0;
    #1;
    chk("mid_rst_vld", ACW'(o_vld), ACW'(1'b0));
    chk("mid_rst_res", ACW'(o_res), ACW'(0));
    #2;
    i_rstn = 1'b1;
    step();
    chk("post_rst_rdy", ACW'(o_rdy), ACW'(1'b1));
    chk("post_rst_vld", ACW'(o_vld), ACW'(1'b0));
    t = 522'd1 << 261;
    run_txn("post_rst", t, 256'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mmm_redc_256b_3way.md
Name: mmm_redc_256b_3way

Overview:
- Stage-2 (reduction) block of the 256-bit NLP/Karatsuba Montgomery multiplier.
- Consumes the 522-bit product T from the stage-1 3-way multiplier.
- Performs digit-serial Montgomery REDC over three 87-bit digits: o_res = T·2^-261 mod M, fully reduced.
- Iterative datapath with a single shared multiplier and valid/ready handshakes on both sides.

Parameters:
IDW, 522, width of incoming product T
MW, 256, modulus width
DIVW, 87, digit width (R = 2^(3·DIVW) = 2^261)
NDIG, 3, number of reduction digits
ACW, 523, accumulator width (IDW+1)

Ports:
i_clk  in  1  clock
i_rstn  in  1  asynchronous, active-low reset
i_vld  in  1  input product valid
o_rdy  out  1  block can accept input this cycle
i_t  in  IDW  product T from stage 1; precondition T < M·2^261
i_m  in  MW  modulus M, odd, 1 < M < 2^256; held stable while busy
i_mp  in  DIVW  M' = -M^-1 mod 2^87
o_vld  out  1  result valid
i_rdy  in  1  downstream accepts result
o_res  out  MW  T·2^-261 mod M, in [0, M)

Behaviour:
- Reset: i_rstn asynchronous, active-low; clock i_clk.
  - Reset values: state=IDLE, o_vld=0, o_res=0, accumulator=0, digit counter=0, o_rdy=1 once in IDLE.
- FSM states: IDLE, QCALC, ACCUM, FSUB, DONE.
- IDLE: o_rdy=1. On i_vld&o_rdy:
  - acc<=zero-extended i_t; latch m_r<=i_m, mp_r<=i_mp; cnt<=0; go to QCALC.
- QCALC: q<=(acc[DIVW-1:0]·mp_r) mod 2^87, using the shared multiplier (mp_r zero-extended to MW). Go to ACCUM.
- ACCUM: acc<=(acc + q·m_r)>>DIVW.
  - Low 87 bits of the sum are zero by construction; a verification assertion checks this.
  - cnt==NDIG-1: go to FSUB; otherwise cnt++ and go to QCALC.
- FSUB: acc<2M is guaranteed.
  - o_res<=(acc>=m_r) ? acc-m_r : acc[MW-1:0]; o_vld<=1; go to DONE.
- DONE: o_vld=1; o_res held stable until i_vld... no: o_res held stable until i_rdy.
  - On i_rdy: o_vld<=0.
  - If i_vld in the same cycle: accept the new T and go to QCALC; otherwise go to IDLE.
- o_rdy = (state==IDLE) | (state==DONE & i_rdy), combinational.
- Latency: accepting edge to o_vld high = 7 clocks (2·NDIG+1). Throughput: one result per 8 cycles with back-to-back handshakes.
- i_vld while busy (QCALC/ACCUM/FSUB, or DONE without i_rdy): ignored, not queued. The upstream holds the data.
- o_vld stays high while i_rdy is low; o_res must not change.
- Widths:
  - q·m_r ≤ 343 bits.
  - acc+q·m_r fits ACW with no overflow.
  - After 3 shifts acc < 2^257.
  - FSUB compares on 257 bits.
- Reset mid-operation: abort immediately to the reset values. The partial result is discarded and no o_vld pulse occurs.
- Precondition violation (T ≥ M·2^261): output is undefined. An assertion in simulation only; no hardware check.

Decomposition:
- Shared package mmm_nlp_pkg holds:
  - constants DIVW=87, NDIG=3, MW=256, IDW=522;
  - state encoding localparams ST_IDLE..ST_DONE.
- One sub-module: mmm_redc_mul_87x256, a combinational 87×256 unsigned multiplier producing 343 bits.
  - Instantiated once; operand mux selects (acc_lo, mp_r) in QCALC and (q, m_r) in ACCUM.
  - Kept separate so it can later be swapped for the mmm_nlp_90b NLP multiplier, or pipelined.

Test Plan:
- M=2^255-19, M' from the bench model, T=0 -> o_vld after exactly 7 cycles, o_res=0.
- Same M, T=2^261 -> o_res=1.
- Same M, T=(M-1)·2^261 -> o_res=M-1; T=M·(2^261-1) -> o_res=0. These exercise the FSUB subtract and no-subtract boundary.
- Random a,b<M, T=a·b, with i_rdy held low 5 cycles after o_vld -> o_res = a·b·2^-261 mod M, stable and o_vld high throughout the stall. i_vld pulses during the stall are ignored.
- Back-to-back: i_vld held high with two products, i_rdy=1 -> second accepted in the DONE/i_rdy cycle, results 8 cycles apart, both match the model.
- i_rstn asserted during the second ACCUM -> o_vld=0, o_res=0, o_rdy=1 after release; the next transaction T=2^261 yields 1.
